// File: rtl/axi_dmac_resize_gen_pkg.sv
// Shared types and elaboration helpers for the DMAC width converter.
// Selects pass-through, downsize or upsize from the two data widths.
package axi_dmac_resize_pkg;

    typedef enum logic [1:0] {
        RESIZE_PASS,
        RESIZE_DOWN,
        RESIZE_UP
    } resize_mode_e;

    function automatic resize_mode_e resize_mode(input int mem, input int dest);
        if (mem > dest) begin
            return RESIZE_DOWN;
        end else if (dest > mem) begin
            return RESIZE_UP;
        end
        return RESIZE_PASS;
    endfunction

    function automatic int resize_ratio(input int mem, input int dest);
        return (mem > dest) ? (mem / dest) : (dest / mem);
    endfunction

    // Legal when both widths are byte multiples and the ratio is a power of two up to 16.
    function automatic bit resize_widths_ok(input int mem, input int dest);
        int w_big;
        int w_small;
        int r;
        w_big   = (mem > dest) ? mem : dest;
        w_small = (mem > dest) ? dest : mem;
        if (w_small <= 0 || (mem % 8) != 0 || (dest % 8) != 0 || (w_big % w_small) != 0) begin
            return 1'b0;
        end
        r = w_big / w_small;
        return (r <= 16) && ((r & (r - 1)) == 0);
    endfunction

endpackage

// File: rtl/axi_dmac_resize_gen_if.sv
// Valid/ready beat stream used on both sides of the width converter.
// Byte-keep lane exists only when AXI_DMAC_RESIZE_KEEP_EN is defined.
interface axi_dmac_resize_gen_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  data_valid;
    logic                  data_ready;
    logic [DATA_WIDTH-1:0] data;
    logic                  data_last;
`ifdef AXI_DMAC_RESIZE_KEEP_EN
    logic [DATA_WIDTH/8-1:0] data_keep;

    modport master (output data_valid, output data, output data_last, output data_keep,
                    input data_ready);
    modport slave  (input data_valid, input data, input data_last, input data_keep,
                    output data_ready);
`else
    modport master (output data_valid, output data, output data_last, input data_ready);
    modport slave  (input data_valid, input data, input data_last, output data_ready);
`endif
endinterface

// File: rtl/axi_dmac_resize_gen_keep_scan.sv
// Flags when every sub-word above the current one has an all-zero keep,
// letting a downsized final word terminate early. Used with AXI_DMAC_RESIZE_KEEP_EN.
module axi_dmac_resize_keep_scan #(
    parameter int RATIO      = 2,
    parameter int LANE_BYTES = 4,
    parameter int CW         = 1
) (
    input  logic [RATIO*LANE_BYTES-1:0] keep,
    input  logic [CW-1:0]               count,
    output logic                        higher_empty
);
    always_comb begin
        higher_empty = 1'b1;
        for (int k = 0; k < RATIO; k++) begin
            if ((k > int'(count)) && (|keep[k*LANE_BYTES +: LANE_BYTES])) begin
                higher_empty = 1'b0;
            end
        end
    end
endmodule

// File: rtl/axi_dmac_resize_gen.sv
// DMAC width converter between memory-side stream and destination interface.
// Optional byte-keep path is enabled by defining AXI_DMAC_RESIZE_KEEP_EN.
module axi_dmac_resize_gen
    import axi_dmac_resize_pkg::*;
#(
    parameter int DATA_WIDTH_MEM  = 64,
    parameter int DATA_WIDTH_DEST = 32
) (
    input logic                   clk,
    input logic                   reset,
    axi_dmac_resize_gen_if.slave  mem,
    axi_dmac_resize_gen_if.master dest
);
    localparam resize_mode_e MODE  = resize_mode(DATA_WIDTH_MEM, DATA_WIDTH_DEST);
    localparam int           RATIO = resize_ratio(DATA_WIDTH_MEM, DATA_WIDTH_DEST);
    localparam int           CW    = (RATIO > 1) ? $clog2(RATIO) : 1;

    if (!resize_widths_ok(DATA_WIDTH_MEM, DATA_WIDTH_DEST)) begin : g_bad_width
        $error("axi_dmac_resize_gen: illegal DATA_WIDTH_MEM/DATA_WIDTH_DEST combination");
    end

    if (MODE == RESIZE_PASS) begin : g_pass
        assign dest.data_valid = mem.data_valid;
        assign mem.data_ready  = dest.data_ready;
        assign dest.data       = mem.data;
        assign dest.data_last  = mem.data_last;
`ifdef AXI_DMAC_RESIZE_KEEP_EN
        assign dest.data_keep  = mem.data_keep;
`endif
    end else if (MODE == RESIZE_DOWN) begin : g_down
        logic                      valid_q, valid_d;
        logic                      last_q, last_d;
        logic [CW-1:0]             count_q, count_d;
        logic [DATA_WIDTH_MEM-1:0] data_q, data_d;
        logic                      last_beat;
        logic                      early_last;
        logic                      load;
        logic                      dest_hs;
`ifdef AXI_DMAC_RESIZE_KEEP_EN
        localparam int KB = DATA_WIDTH_DEST / 8;
        logic [DATA_WIDTH_MEM/8-1:0] keep_q, keep_d;
        logic                        higher_empty;

        axi_dmac_resize_keep_scan #(
            .RATIO      (RATIO),
            .LANE_BYTES (KB),
            .CW         (CW)
        ) u_keep_scan (
            .keep         (keep_q),
            .count        (count_q),
            .higher_empty (higher_empty)
        );

        // A final word whose upper sub-words carry no bytes ends at the current sub-word.
        assign early_last     = last_q & higher_empty;
        assign dest.data_keep = keep_q[int'(count_q)*KB +: KB];
`else
        assign early_last = 1'b0;
`endif

        assign last_beat       = (count_q == CW'(RATIO - 1)) | early_last;
        assign dest_hs         = valid_q & dest.data_ready;
        assign mem.data_ready  = ~valid_q | (dest.data_ready & last_beat);
        assign load            = mem.data_valid & mem.data_ready;
        assign dest.data_valid = valid_q;
        assign dest.data       = data_q[int'(count_q)*DATA_WIDTH_DEST +: DATA_WIDTH_DEST];
        assign dest.data_last  = last_q & last_beat;

        always_comb begin
            valid_d = valid_q;
            last_d  = last_q;
            count_d = count_q;
            data_d  = data_q;
`ifdef AXI_DMAC_RESIZE_KEEP_EN
            keep_d  = keep_q;
`endif
            if (load) begin
                valid_d = 1'b1;
                count_d = '0;
                data_d  = mem.data;
                last_d  = mem.data_last;
`ifdef AXI_DMAC_RESIZE_KEEP_EN
                keep_d  = mem.data_keep;
`endif
            end else if (dest_hs) begin
                if (last_beat) begin
                    valid_d = 1'b0;
                    count_d = '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
                count_q <= '0;
                data_q  <= '0;
`ifdef AXI_DMAC_RESIZE_KEEP_EN
                keep_q  <= '0;
`endif
            end else begin
                valid_q <= valid_d;
                last_q  <= last_d;
                count_q <= count_d;
                data_q  <= data_d;
`ifdef AXI_DMAC_RESIZE_KEEP_EN
                keep_q  <= keep_d;
`endif
            end
        end
    end else begin : g_up
        logic                       valid_q, valid_d;
        logic                       last_q, last_d;
        logic [CW-1:0]              count_q, count_d;
        logic [DATA_WIDTH_DEST-1:0] data_q, data_d;
        logic                       mem_hs;
        logic                       dest_hs;
`ifdef AXI_DMAC_RESIZE_KEEP_EN
        localparam int KB = DATA_WIDTH_MEM / 8;
        logic [DATA_WIDTH_DEST/8-1:0] keep_q, keep_d;

        assign dest.data_keep = keep_q;
`endif

        // Accumulation and output share one register; a drain frees it the same cycle.
        assign mem.data_ready  = ~valid_q | dest.data_ready;
        assign mem_hs          = mem.data_valid & mem.data_ready;
        assign dest_hs         = valid_q & dest.data_ready;
        assign dest.data_valid = valid_q;
        assign dest.data       = data_q;
        assign dest.data_last  = last_q;

        always_comb begin
            valid_d = valid_q;
            last_d  = last_q;
            count_d = count_q;
            data_d  = data_q;
`ifdef AXI_DMAC_RESIZE_KEEP_EN
            keep_d  = keep_q;
`endif
            if (dest_hs) begin
                valid_d = 1'b0;
            end
            if (mem_hs) begin
                if (count_q == '0) begin
                    data_d = '0;
`ifdef AXI_DMAC_RESIZE_KEEP_EN
                    keep_d = '0;
`endif
                end
                data_d[int'(count_q)*DATA_WIDTH_MEM +: DATA_WIDTH_MEM] = mem.data;
`ifdef AXI_DMAC_RESIZE_KEEP_EN
                keep_d[int'(count_q)*KB +: KB] = mem.data_keep;
`endif
                if ((count_q == CW'(RATIO - 1)) || mem.data_last) begin
                    valid_d = 1'b1;
                    last_d  = mem.data_last;
                    count_d = '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
                count_q <= '0;
                data_q  <= '0;
`ifdef AXI_DMAC_RESIZE_KEEP_EN
                keep_q  <= '0;
`endif
            end else begin
                valid_q <= valid_d;
                last_q  <= last_d;
                count_q <= count_d;
                data_q  <= data_d;
`ifdef AXI_DMAC_RESIZE_KEEP_EN
                keep_q  <= keep_d;
`endif
            end
        end
    end

endmodule

// File: tb/tb_axi_dmac_resize_gen.sv
// Bench for axi_dmac_resize_gen: downsize 64->32, upsize 32->64 and 32->128, pass 32->32.
// Expected beats come from a slicing/packing scoreboard built from the source stream.
module tb_axi_dmac_resize_gen;

    typedef struct {
        logic [127:0] data;
        logic         last;
        logic [15:0]  keep;
    } beat_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    axi_dmac_resize_gen_if #(.DATA_WIDTH(64))  dn_mem ();
    axi_dmac_resize_gen_if #(.DATA_WIDTH(32))  dn_dst ();
    axi_dmac_resize_gen_if #(.DATA_WIDTH(32))  u2_mem ();
    axi_dmac_resize_gen_if #(.DATA_WIDTH(64))  u2_dst ();
    axi_dmac_resize_gen_if #(.DATA_WIDTH(32))  u4_mem ();
    axi_dmac_resize_gen_if #(.DATA_WIDTH(128)) u4_dst ();
    axi_dmac_resize_gen_if #(.DATA_WIDTH(32))  ps_mem ();
    axi_dmac_resize_gen_if #(.DATA_WIDTH(32))  ps_dst ();

    axi_dmac_resize_gen #(.DATA_WIDTH_MEM(64), .DATA_WIDTH_DEST(32)) u_dn (
        .clk(clk), .reset(reset), .mem(dn_mem), .dest(dn_dst));
    axi_dmac_resize_gen #(.DATA_WIDTH_MEM(32), .DATA_WIDTH_DEST(64)) u_u2 (
        .clk(clk), .reset(reset), .mem(u2_mem), .dest(u2_dst));
    axi_dmac_resize_gen #(.DATA_WIDTH_MEM(32), .DATA_WIDTH_DEST(128)) u_u4 (
        .clk(clk), .reset(reset), .mem(u4_mem), .dest(u4_dst));
    axi_dmac_resize_gen #(.DATA_WIDTH_MEM(32), .DATA_WIDTH_DEST(32)) u_ps (
        .clk(clk), .reset(reset), .mem(ps_mem), .dest(ps_dst));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        reset = 1'b0;
        dn_mem.data_valid = 1'b0; dn_mem.data = '0; dn_mem.data_last = 1'b0; dn_dst.data_ready = 1'b0;
        u2_mem.data_valid = 1'b0; u2_mem.data = '0; u2_mem.data_last = 1'b0; u2_dst.data_ready = 1'b0;
        u4_mem.data_valid = 1'b0; u4_mem.data = '0; u4_mem.data_last = 1'b0; u4_dst.data_ready = 1'b0;
        ps_mem.data_valid = 1'b0; ps_mem.data = '0; ps_mem.data_last = 1'b0; ps_dst.data_ready = 1'b0;
`ifdef AXI_DMAC_RESIZE_KEEP_EN
        dn_mem.data_keep = '1; u2_mem.data_keep = '1; u4_mem.data_keep = '1; ps_mem.data_keep = '1;
`endif
        #3 reset = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (dn_dst.data_valid !== 1'b0 || dn_dst.data !== 32'h0 || dn_dst.data_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_down: got v=%b d=%h l=%b expected v=0 d=0 l=0",
                     dn_dst.data_valid, dn_dst.data, dn_dst.data_last);
        end
        checks++;
        if (u4_dst.data_valid !== 1'b0 || u4_dst.data !== 128'h0 || u4_dst.data_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_up: got v=%b d=%h l=%b expected v=0 d=0 l=0",
                     u4_dst.data_valid, u4_dst.data, u4_dst.data_last);
        end
`ifdef AXI_DMAC_RESIZE_KEEP_EN
        checks++;
        if (dn_dst.data_keep !== 4'h0 || u4_dst.data_keep !== 16'h0) begin
            errors++;
            $display("FAIL reset_keep: got %h/%h expected 0/0", dn_dst.data_keep, u4_dst.data_keep);
        end
`endif
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (dn_mem.data_ready !== 1'b1 || u2_mem.data_ready !== 1'b1 || u4_mem.data_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mem_ready: got %b%b%b expected 111",
                     dn_mem.data_ready, u2_mem.data_ready, u4_mem.data_ready);
        end
        checks++;
        if (ps_mem.data_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_pass_ready_lo: got %b expected 0", ps_mem.data_ready);
        end
        ps_dst.data_ready = 1'b1;
        #1;
        checks++;
        if (ps_mem.data_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_pass_ready_hi: got %b expected 1", ps_mem.data_ready);
        end
    endtask

    task automatic test_pass_random();
        logic [31:0] d;
        logic v, l, r;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            d = $urandom(); v = 1'($urandom_range(0, 1)); l = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            ps_mem.data = d; ps_mem.data_valid = v; ps_mem.data_last = l; ps_dst.data_ready = r;
            #1;
            checks++;
            if (ps_dst.data_valid !== v || ps_dst.data !== d || ps_dst.data_last !== l || ps_mem.data_ready !== r) begin
                errors++;
                $display("FAIL pass_through: got v=%b d=%h l=%b rdy=%b expected v=%b d=%h l=%b rdy=%b",
                         ps_dst.data_valid, ps_dst.data, ps_dst.data_last, ps_mem.data_ready, v, d, l, r);
            end
        end
        @(negedge clk);
        ps_mem.data_valid = 1'b0;
    endtask

    task automatic test_down_basic();
        @(negedge clk);
        dn_dst.data_ready = 1'b1;
        dn_mem.data_valid = 1'b1; dn_mem.data = 64'h11112222_33334444; dn_mem.data_last = 1'b1;
        #1;
        checks++;
        if (dn_mem.data_ready !== 1'b1) begin
            errors++; $display("FAIL down_accept: got ready=%b expected 1", dn_mem.data_ready);
        end
        @(negedge clk);
        dn_mem.data = 64'hAAAABBBB_CCCCDDDD; dn_mem.data_last = 1'b1;
        #1;
        checks++;
        if (dn_dst.data_valid !== 1'b1 || dn_dst.data !== 32'h33334444 || dn_dst.data_last !== 1'b0 || dn_mem.data_ready !== 1'b0) begin
            errors++;
            $display("FAIL down_sub0: got v=%b d=%h l=%b rdy=%b expected v=1 d=33334444 l=0 rdy=0",
                     dn_dst.data_valid, dn_dst.data, dn_dst.data_last, dn_mem.data_ready);
        end
        @(negedge clk); #1;
        checks++;
        if (dn_dst.data_valid !== 1'b1 || dn_dst.data !== 32'h11112222 || dn_dst.data_last !== 1'b1 || dn_mem.data_ready !== 1'b1) begin
            errors++;
            $display("FAIL down_sub1: got v=%b d=%h l=%b rdy=%b expected v=1 d=11112222 l=1 rdy=1",
                     dn_dst.data_valid, dn_dst.data, dn_dst.data_last, dn_mem.data_ready);
        end
        @(negedge clk);
        dn_mem.data_valid = 1'b0;
        #1;
        checks++;
        if (dn_dst.data_valid !== 1'b1 || dn_dst.data !== 32'hCCCCDDDD || dn_dst.data_last !== 1'b0) begin
            errors++;
            $display("FAIL down_back_to_back: got v=%b d=%h l=%b expected v=1 d=ccccdddd l=0",
                     dn_dst.data_valid, dn_dst.data, dn_dst.data_last);
        end
        @(negedge clk); #1;
        checks++;
        if (dn_dst.data_valid !== 1'b1 || dn_dst.data !== 32'hAAAABBBB || dn_dst.data_last !== 1'b1) begin
            errors++;
            $display("FAIL down_b2b_sub1: got v=%b d=%h l=%b expected v=1 d=aaaabbbb l=1",
                     dn_dst.data_valid, dn_dst.data, dn_dst.data_last);
        end
        @(negedge clk); #1;
        checks++;
        if (dn_dst.data_valid !== 1'b0) begin
            errors++; $display("FAIL down_idle: got v=%b expected 0", dn_dst.data_valid);
        end
    endtask

`ifdef AXI_DMAC_RESIZE_KEEP_EN
    task automatic test_down_keep_early();
        @(negedge clk);
        dn_dst.data_ready = 1'b1;
        dn_mem.data_valid = 1'b1; dn_mem.data = 64'h55556666_77778888; dn_mem.data_last = 1'b1;
        dn_mem.data_keep = 8'h0F;
        @(negedge clk);
        dn_mem.data = 64'h9999AAAA_BBBBCCCC; dn_mem.data_keep = 8'hFF; dn_mem.data_last = 1'b1;
        #1;
        checks++;
        if (dn_dst.data !== 32'h77778888 || dn_dst.data_last !== 1'b1 || dn_dst.data_keep !== 4'hF || dn_mem.data_ready !== 1'b1) begin
            errors++;
            $display("FAIL keep_early: got d=%h l=%b k=%h rdy=%b expected d=77778888 l=1 k=f rdy=1",
                     dn_dst.data, dn_dst.data_last, dn_dst.data_keep, dn_mem.data_ready);
        end
        @(negedge clk);
        dn_mem.data_valid = 1'b0;
        #1;
        checks++;
        if (dn_dst.data_valid !== 1'b1 || dn_dst.data !== 32'hBBBBCCCC || dn_dst.data_last !== 1'b0) begin
            errors++;
            $display("FAIL keep_next_word: got v=%b d=%h l=%b expected v=1 d=bbbbcccc l=0",
                     dn_dst.data_valid, dn_dst.data, dn_dst.data_last);
        end
        @(negedge clk);
        @(negedge clk);
    endtask
`endif

    task automatic test_stall();
        logic [31:0] held;
        @(negedge clk);
        dn_dst.data_ready = 1'b0;
        dn_mem.data_valid = 1'b1; dn_mem.data = 64'h0BAD0001_0BAD0000; dn_mem.data_last = 1'b0;
        @(negedge clk);
        dn_mem.data = 64'h0CAB0003_0CAB0002; dn_mem.data_last = 1'b1;
        #1;
        held = dn_dst.data;
        checks++;
        if (held !== 32'h0BAD0000 || dn_mem.data_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_first: got d=%h rdy=%b expected d=0bad0000 rdy=0", held, dn_mem.data_ready);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++;
            if (dn_dst.data_valid !== 1'b1 || dn_dst.data !== held || dn_dst.data_last !== 1'b0 || dn_mem.data_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: got v=%b d=%h l=%b rdy=%b expected v=1 d=%h l=0 rdy=0",
                         dn_dst.data_valid, dn_dst.data, dn_dst.data_last, dn_mem.data_ready, held);
            end
        end
        @(negedge clk);
        dn_dst.data_ready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (dn_dst.data !== 32'h0BAD0001 || dn_dst.data_last !== 1'b0 || dn_mem.data_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_resume: got d=%h l=%b rdy=%b expected d=0bad0001 l=0 rdy=1",
                     dn_dst.data, dn_dst.data_last, dn_mem.data_ready);
        end
        @(negedge clk);
        dn_mem.data_valid = 1'b0;
        #1;
        checks++;
        if (dn_dst.data_valid !== 1'b1 || dn_dst.data !== 32'h0CAB0002) begin
            errors++;
            $display("FAIL stall_next: got v=%b d=%h expected v=1 d=0cab0002", dn_dst.data_valid, dn_dst.data);
        end
        @(negedge clk); #1;
        checks++;
        if (dn_dst.data !== 32'h0CAB0003 || dn_dst.data_last !== 1'b1) begin
            errors++;
            $display("FAIL stall_tail: got d=%h l=%b expected d=0cab0003 l=1", dn_dst.data, dn_dst.data_last);
        end
        @(negedge clk);
    endtask

    task automatic test_up2_basic();
        @(negedge clk);
        u2_dst.data_ready = 1'b1;
        u2_mem.data_valid = 1'b1; u2_mem.data = 32'hAAAA0000; u2_mem.data_last = 1'b0;
        @(negedge clk);
        u2_mem.data = 32'hBBBB1111;
        #1;
        checks++;
        if (u2_dst.data_valid !== 1'b0) begin
            errors++; $display("FAIL up2_early: got v=%b expected 0", u2_dst.data_valid);
        end
        @(negedge clk);
        u2_mem.data_valid = 1'b0;
        #1;
        checks++;
        if (u2_dst.data_valid !== 1'b1 || u2_dst.data !== 64'hBBBB1111_AAAA0000 || u2_dst.data_last !== 1'b0) begin
            errors++;
            $display("FAIL up2_word: got v=%b d=%h l=%b expected v=1 d=bbbb1111aaaa0000 l=0",
                     u2_dst.data_valid, u2_dst.data, u2_dst.data_last);
        end
        @(negedge clk);
    endtask

    task automatic test_up4_partial();
        @(negedge clk);
        u4_dst.data_ready = 1'b1;
        u4_mem.data_valid = 1'b1; u4_mem.data = 32'h11111111; u4_mem.data_last = 1'b0;
        @(negedge clk);
        u4_mem.data = 32'h22222222;
        @(negedge clk);
        u4_mem.data = 32'h33333333; u4_mem.data_last = 1'b1;
        @(negedge clk);
        u4_mem.data_valid = 1'b0; u4_mem.data_last = 1'b0;
        #1;
        checks++;
        if (u4_dst.data_valid !== 1'b1 || u4_dst.data !== 128'h00000000_33333333_22222222_11111111 || u4_dst.data_last !== 1'b1) begin
            errors++;
            $display("FAIL up4_partial: got v=%b d=%h l=%b expected v=1 d=00000000333333332222222211111111 l=1",
                     u4_dst.data_valid, u4_dst.data, u4_dst.data_last);
        end
`ifdef AXI_DMAC_RESIZE_KEEP_EN
        checks++;
        if (u4_dst.data_keep !== 16'h0FFF) begin
            errors++; $display("FAIL up4_keep: got %h expected 0fff", u4_dst.data_keep);
        end
`endif
        @(negedge clk); #1;
        checks++;
        if (u4_dst.data_valid !== 1'b0) begin
            errors++; $display("FAIL up4_single_beat: got v=%b expected 0", u4_dst.data_valid);
        end
    endtask

    task automatic test_down_random();
        beat_t src[$];
        beat_t exp[$];
        beat_t b;
        beat_t e;
        int idx, cyc;
        bit pend, prev_stall;
        logic [31:0] prev_data;
        logic prev_last;
        idx = 0; cyc = 0; pend = 0; prev_stall = 0; prev_data = '0; prev_last = 1'b0;
        for (int i = 0; i < 48; i++) begin
            b.data = {64'h0, $urandom(), $urandom()};
            b.last = (i == 47) || ($urandom_range(0, 3) == 0);
            b.keep = 16'hFF;
            src.push_back(b);
        end
        foreach (src[i]) begin
            for (int k = 0; k < 2; k++) begin
                e.data = (src[i].data >> (32 * k)) & 128'hFFFF_FFFF;
                e.last = src[i].last && (k == 1);
                e.keep = 16'hF;
                exp.push_back(e);
            end
        end
        while ((idx < src.size() || exp.size() != 0) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (!pend && idx < src.size() && $urandom_range(0, 3) != 0) pend = 1;
            dn_mem.data_valid = pend;
            if (idx < src.size()) begin
                dn_mem.data = src[idx].data[63:0];
                dn_mem.data_last = src[idx].last;
            end
            dn_dst.data_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (prev_stall) begin
                checks++;
                if (dn_dst.data_valid !== 1'b1 || dn_dst.data !== prev_data || dn_dst.data_last !== prev_last) begin
                    errors++;
                    $display("FAIL down_rand_stable: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                             dn_dst.data_valid, dn_dst.data, dn_dst.data_last, prev_data, prev_last);
                end
            end
            if (dn_dst.data_valid === 1'b1 && dn_dst.data_ready === 1'b1) begin
                checks++;
                if (exp.size() == 0) begin
                    errors++; $display("FAIL down_rand_extra: got beat %h expected none", dn_dst.data);
                end else begin
                    e = exp.pop_front();
                    if (dn_dst.data !== e.data[31:0] || dn_dst.data_last !== e.last) begin
                        errors++;
                        $display("FAIL down_rand_beat: got d=%h l=%b expected d=%h l=%b",
                                 dn_dst.data, dn_dst.data_last, e.data[31:0], e.last);
                    end
`ifdef AXI_DMAC_RESIZE_KEEP_EN
                    checks++;
                    if (dn_dst.data_keep !== e.keep[3:0]) begin
                        errors++; $display("FAIL down_rand_keep: got %h expected %h", dn_dst.data_keep, e.keep[3:0]);
                    end
`endif
                end
            end
            prev_stall = (dn_dst.data_valid === 1'b1) && (dn_dst.data_ready === 1'b0);
            prev_data = dn_dst.data;
            prev_last = dn_dst.data_last;
            if (dn_mem.data_valid === 1'b1 && dn_mem.data_ready === 1'b1) begin
                pend = 0;
                idx++;
            end
        end
        checks++;
        if (cyc >= 3000 || idx != src.size() || exp.size() != 0) begin
            errors++;
            $display("FAIL down_rand_drain: got consumed=%0d pending=%0d cycles=%0d expected consumed=%0d pending=0",
                     idx, exp.size(), cyc, src.size());
        end
        @(negedge clk);
        dn_mem.data_valid = 1'b0;
    endtask

    task automatic test_up4_random();
        beat_t src[$];
        beat_t exp[$];
        beat_t b;
        beat_t e;
        beat_t cur;
        int n, idx, cyc;
        bit pend, prev_stall;
        logic [127:0] prev_data;
        logic prev_last;
        idx = 0; cyc = 0; pend = 0; prev_stall = 0; prev_data = '0; prev_last = 1'b0;
        for (int i = 0; i < 60; i++) begin
            b.data = {96'h0, $urandom()};
            b.last = (i == 59) || ($urandom_range(0, 4) == 0);
            b.keep = 16'hF;
            src.push_back(b);
        end
        n = 0; cur.data = '0; cur.keep = '0; cur.last = 1'b0;
        foreach (src[i]) begin
            cur.data = cur.data | (src[i].data << (32 * n));
            cur.keep = cur.keep | (16'hF << (4 * n));
            n++;
            if (n == 4 || src[i].last) begin
                cur.last = src[i].last;
                exp.push_back(cur);
                cur.data = '0; cur.keep = '0; n = 0;
            end
        end
        while ((idx < src.size() || exp.size() != 0) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (!pend && idx < src.size() && $urandom_range(0, 4) != 0) pend = 1;
            u4_mem.data_valid = pend;
            if (idx < src.size()) begin
                u4_mem.data = src[idx].data[31:0];
                u4_mem.data_last = src[idx].last;
            end
            u4_dst.data_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (prev_stall) begin
                checks++;
                if (u4_dst.data_valid !== 1'b1 || u4_dst.data !== prev_data || u4_dst.data_last !== prev_last) begin
                    errors++;
                    $display("FAIL up_rand_stable: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                             u4_dst.data_valid, u4_dst.data, u4_dst.data_last, prev_data, prev_last);
                end
            end
            if (u4_dst.data_valid === 1'b1 && u4_dst.data_ready === 1'b1) begin
                checks++;
                if (exp.size() == 0) begin
                    errors++; $display("FAIL up_rand_extra: got beat %h expected none", u4_dst.data);
                end else begin
                    e = exp.pop_front();
                    if (u4_dst.data !== e.data || u4_dst.data_last !== e.last) begin
                        errors++;
                        $display("FAIL up_rand_beat: got d=%h l=%b expected d=%h l=%b",
                                 u4_dst.data, u4_dst.data_last, e.data, e.last);
                    end
`ifdef AXI_DMAC_RESIZE_KEEP_EN
                    checks++;
                    if (u4_dst.data_keep !== e.keep) begin
                        errors++; $display("FAIL up_rand_keep: got %h expected %h", u4_dst.data_keep, e.keep);
                    end
`endif
                end
            end
            prev_stall = (u4_dst.data_valid === 1'b1) && (u4_dst.data_ready === 1'b0);
            prev_data = u4_dst.data;
            prev_last = u4_dst.data_last;
            if (u4_mem.data_valid === 1'b1 && u4_mem.data_ready === 1'b1) begin
                pend = 0;
                idx++;
            end
        end
        checks++;
        if (cyc >= 3000 || idx != src.size() || exp.size() != 0) begin
            errors++;
            $display("FAIL up_rand_drain: got consumed=%0d pending=%0d cycles=%0d expected consumed=%0d pending=0",
                     idx, exp.size(), cyc, src.size());
        end
        @(negedge clk);
        u4_mem.data_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        dn_dst.data_ready = 1'b1;
        dn_mem.data_valid = 1'b1; dn_mem.data = 64'hFEED0001_FEED0000; dn_mem.data_last = 1'b1;
        @(negedge clk);
        dn_mem.data_valid = 1'b0;
        #1;
        checks++;
        if (dn_dst.data !== 32'hFEED0000) begin
            errors++; $display("FAIL areset_pre: got d=%h expected feed0000", dn_dst.data);
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (dn_dst.data_valid !== 1'b0 || dn_dst.data !== 32'h0 || dn_dst.data_last !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate: got v=%b d=%h l=%b expected v=0 d=0 l=0",
                     dn_dst.data_valid, dn_dst.data, dn_dst.data_last);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        dn_mem.data_valid = 1'b1; dn_mem.data = 64'hC0DE0001_C0DE0000; dn_mem.data_last = 1'b1;
        @(negedge clk);
        dn_mem.data_valid = 1'b0;
        #1;
        checks++;
        if (dn_dst.data_valid !== 1'b1 || dn_dst.data !== 32'hC0DE0000 || dn_dst.data_last !== 1'b0) begin
            errors++;
            $display("FAIL areset_sub0: got v=%b d=%h l=%b expected v=1 d=c0de0000 l=0",
                     dn_dst.data_valid, dn_dst.data, dn_dst.data_last);
        end
        @(negedge clk); #1;
        checks++;
        if (dn_dst.data !== 32'hC0DE0001 || dn_dst.data_last !== 1'b1) begin
            errors++;
            $display("FAIL areset_sub1: got d=%h l=%b expected d=c0de0001 l=1", dn_dst.data, dn_dst.data_last);
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_pass_random();
        test_down_basic();
`ifdef AXI_DMAC_RESIZE_KEEP_EN
        test_down_keep_early();
`endif
        test_stall();
        test_up2_basic();
        test_up4_partial();
        test_down_random();
        test_up4_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
